// File: rtl/game_timer_pkg.sv
// Shared types and constants for the Frog-Hunter countdown clock.
package game_timer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUNNING  = 2'd1,
        PAUSED   = 2'd2,
        EXPIRED  = 2'd3
    } state_e;

    localparam logic [3:0] SEC_ONES_MAX = 4'd9;
    localparam logic [2:0] SEC_TENS_MAX = 3'd5;

    function automatic logic is_zero_time(
        input logic [2:0] m2,
        input logic [3:0] m1,
        input logic [2:0] s2,
        input logic [3:0] s1
    );
        return (m2 == 3'd0) && (m1 == 4'd0) && (s2 == 3'd0) && (s1 == 4'd0);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_max;

    // The count only advances while run is high, so a paused clock resumes mid-second.
    always_comb begin
        at_max  = (count_q == CNT_MAX);
        count_d = count_q;
        if (run) begin
            count_d = at_max ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = run && at_max;

endmodule

// File: rtl/game_timer_ctrl.sv
// Countdown sequencer: owns the seconds digits, borrows from the external minutes
// counter via enable_m, and tracks the IDLE/RUNNING/PAUSED/EXPIRED lifecycle.
module game_timer_ctrl
    import game_timer_pkg::*;
#(
    parameter int         TICK_DIV = 100_000_000,
    parameter logic [3:0] START_S1 = 4'd0,
    parameter logic [2:0] START_S2 = 3'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] m1,
    input  logic [2:0] m2,
    output logic       enable_m,
    output logic [3:0] s1,
    output logic [2:0] s2,
    output logic       time_up,
    output logic [1:0] state
);

    state_e     state_q;
    state_e     state_d;
    logic [3:0] s1_q;
    logic [3:0] s1_d;
    logic [2:0] s2_q;
    logic [2:0] s2_d;
    logic       enable_m_q;
    logic       enable_m_d;
    logic       time_up_q;
    logic       time_up_d;

    logic       run;
    logic       tick;
    logic       min_zero;
    logic       sec_zero;
    logic       expire_tick;

    // A pause request wins over a coincident tick: run drops, so the tick never fires.
    assign run = (state_q == RUNNING) && !pause;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .tick  (tick)
    );

    assign min_zero = (m1 == 4'd0) && (m2 == 3'd0);
    assign sec_zero = (s1_q == 4'd0) && (s2_q == 3'd0);

    // Minutes are compared pre-update; no borrow is ever in flight once they reach zero.
    assign expire_tick = tick && min_zero &&
                         (sec_zero || ((s2_q == 3'd0) && (s1_q == 4'd1)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && !pause) begin
                    state_d = is_zero_time(m2, m1, s2_q, s1_q) ? EXPIRED : RUNNING;
                end
            end
            RUNNING: begin
                if (pause) begin
                    state_d = PAUSED;
                end else if (expire_tick) begin
                    state_d = EXPIRED;
                end
            end
            PAUSED: begin
                if (!pause) begin
                    state_d = RUNNING;
                end
            end
            EXPIRED: state_d = EXPIRED;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s1_d       = s1_q;
        s2_d       = s2_q;
        enable_m_d = 1'b0;
        time_up_d  = (state_q == EXPIRED);
        if (tick) begin
            if (s1_q != 4'd0) begin
                s1_d = s1_q - 4'd1;
            end else if (s2_q != 3'd0) begin
                s1_d = SEC_ONES_MAX;
                s2_d = s2_q - 3'd1;
            end else if (!min_zero) begin
                s1_d       = SEC_ONES_MAX;
                s2_d       = SEC_TENS_MAX;
                enable_m_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q       <= START_S1;
            s2_q       <= START_S2;
            enable_m_q <= 1'b0;
            time_up_q  <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            enable_m_q <= enable_m_d;
            time_up_q  <= time_up_d;
        end
    end

    assign s1       = s1_q;
    assign s2       = s2_q;
    assign enable_m = enable_m_q;
    assign time_up  = time_up_q;
    assign state    = state_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed bench for game_timer_ctrl with a BCD minutes model and a seconds scoreboard.
module tb_game_timer_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       pause;
    logic [3:0] m1;
    logic [2:0] m2;
    logic       enable_m;
    logic [3:0] s1;
    logic [2:0] s2;
    logic       time_up;
    logic [1:0] state;

    int checks = 0;
    int passed = 0;
    int fails = 0;
    int en_count = 0;
    int en_base = 0;
    int hold = 0;
    int prev_digits = 0;
    bit sb_on = 1'b0;
    int exp_q[$];

    game_timer_ctrl #(
        .TICK_DIV (4),
        .START_S1 (4'd0),
        .START_S2 (3'd0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .pause    (pause),
        .m1       (m1),
        .m2       (m2),
        .enable_m (enable_m),
        .s1       (s1),
        .s2       (s2),
        .time_up  (time_up),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int digits();
        return int'({s2, s1});
    endfunction

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Expected seconds readings for a run starting at total_s seconds, down to 0:00.
    task automatic push_run(input int total_s);
        int x;
        for (int k = 1; k <= total_s; k++) begin
            x = (total_s - k) % 60;
            exp_q.push_back((x / 10) * 16 + (x % 10));
        end
    endtask

    // One clock: apply minutes decrement for a pulse seen in the last cycle,
    // count borrow pulses and pop the scoreboard on every seconds change.
    task automatic step();
        logic en;
        int   cur;
        int   e;
        en = enable_m;
        @(posedge clk);
        #1;
        if (en === 1'b1) begin
            if (m1 == 4'd0) begin
                m1 = 4'd9;
                m2 = m2 - 3'd1;
            end else begin
                m1 = m1 - 4'd1;
            end
        end
        if (enable_m === 1'b1) begin
            en_count++;
            chk("enable_m_single_cycle", int'(en), 0);
        end
        cur = digits();
        if (sb_on && cur != prev_digits) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_change", cur, prev_digits);
            end else begin
                e = exp_q.pop_front();
                chk("sb_seconds", cur, e);
            end
        end
        prev_digits = cur;
    endtask

    task automatic run_until(input int target, input string tag);
        int n;
        n = 0;
        while (digits() != target && n < 400) begin
            step();
            n++;
        end
        chk(tag, digits(), target);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        m1    = 4'd1;
        m2    = 3'd0;

        // Reset then run
        step();
        step();
        chk("reset_state", int'(state), 0);
        chk("reset_s1", int'(s1), 0);
        chk("reset_s2", int'(s2), 0);
        chk("reset_enable_m", int'(enable_m), 0);
        chk("reset_time_up", int'(time_up), 0);
        rst_n = 1'b1;
        step();
        chk("idle_without_start", int'(state), 0);
        start = 1'b1;
        prev_digits = digits();
        push_run(60);
        sb_on = 1'b1;
        step();
        chk("start_to_running", int'(state), 1);
        repeat (3) step();
        chk("no_early_tick", digits(), 0);
        step();
        chk("first_tick_digits", digits(), 'h59);
        chk("borrow_pulse", int'(enable_m), 1);
        chk("minutes_before_update", int'(m1), 1);
        step();
        chk("borrow_pulse_ends", int'(enable_m), 0);
        chk("minutes_after_borrow", int'(m1), 0);
        chk("borrow_count", en_count, 1);

        // Pause with the prescaler at 2
        run_until('h50, "reach_0_50");
        step();
        step();
        hold = digits();
        pause = 1'b1;
        step();
        chk("paused_state", int'(state), 2);
        repeat (19) step();
        chk("paused_state_end", int'(state), 2);
        chk("paused_digits_frozen", digits(), hold);
        pause = 1'b0;
        step();
        chk("resume_state", int'(state), 1);
        chk("resume_no_tick_0", digits(), hold);
        step();
        chk("resume_no_tick_1", digits(), hold);
        step();
        chk("resume_tick", digits(), 'h49);

        // Reset mid-count with the prescaler at 2
        run_until('h37, "reach_0_37");
        step();
        step();
        rst_n = 1'b0;
        sb_on = 1'b0;
        exp_q.delete();
        step();
        chk("midrst_state", int'(state), 0);
        chk("midrst_digits", digits(), 0);
        chk("midrst_enable_m", int'(enable_m), 0);
        chk("midrst_time_up", int'(time_up), 0);

        // Full countdown from 1:00 (also proves the prescaler was cleared)
        rst_n = 1'b1;
        start = 1'b0;
        m1 = 4'd1;
        m2 = 3'd0;
        step();
        chk("post_reset_idle", int'(state), 0);
        start = 1'b1;
        prev_digits = digits();
        push_run(60);
        sb_on = 1'b1;
        en_base = en_count;
        step();
        chk("restart_running", int'(state), 1);
        repeat (3) step();
        chk("prescaler_cleared", digits(), 0);
        step();
        chk("restart_first_tick", digits(), 'h59);
        run_until(0, "reach_0_00");
        chk("expired_with_digits", int'(state), 3);
        chk("time_up_lags", int'(time_up), 0);
        step();
        chk("time_up_set", int'(time_up), 1);
        pause = 1'b1;
        start = 1'b0;
        repeat (4) step();
        pause = 1'b0;
        start = 1'b1;
        repeat (4) step();
        chk("expired_sticky", int'(state), 3);
        chk("expired_digits_hold", digits(), 0);
        chk("expired_time_up_hold", int'(time_up), 1);
        chk("run_pulse_count", en_count - en_base, 1);
        chk("scoreboard_drained", exp_q.size(), 0);

        // Simultaneous start and pause in IDLE
        rst_n = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        sb_on = 1'b0;
        step();
        rst_n = 1'b1;
        m1 = 4'd1;
        m2 = 3'd0;
        start = 1'b1;
        pause = 1'b1;
        step();
        step();
        chk("start_pause_stays_idle", int'(state), 0);
        pause = 1'b0;
        step();
        chk("pause_drop_running", int'(state), 1);

        // Start at 0:00
        rst_n = 1'b0;
        start = 1'b0;
        step();
        chk("zero_reset_idle", int'(state), 0);
        rst_n = 1'b1;
        m1 = 4'd0;
        m2 = 3'd0;
        step();
        en_base = en_count;
        start = 1'b1;
        step();
        chk("zero_start_expired", int'(state), 3);
        chk("zero_start_time_up_lag", int'(time_up), 0);
        step();
        chk("zero_start_time_up", int'(time_up), 1);
        repeat (6) step();
        chk("zero_start_no_pulses", en_count - en_base, 0);
        chk("zero_start_digits", digits(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/game_timer_ctrl.md
# game_timer_ctrl

Sequencer for the Frog-Hunter countdown clock. It derives a one-second tick from `clk`, owns the seconds digits, and issues the single-cycle `enable_m` borrow pulses to the external minutes counter. It also gates the countdown through start, pause and expiry states, and raises `time_up` for the game FSM and display logic when the clock reaches 0:00.

## Interface

Parameters:
- `TICK_DIV`, default 100_000_000: `clk` cycles per one-second tick. Must be ≥ 2.
- `START_S1`, default 0: seconds ones digit loaded at reset (0–9).
- `START_S2`, default 0: seconds tens digit loaded at reset (0–5).

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  level. IDLE → RUNNING when high and `pause` is low.
- `pause`  in  1  level. While high, counting is frozen.
- `m1`  in  4  minutes ones digit, read back from the minutes counter.
- `m2`  in  3  minutes tens digit, read back from the minutes counter.
- `enable_m`  out  1  registered one-cycle pulse that decrements the minutes counter.
- `s1`  out  4  seconds ones digit (BCD 0–9).
- `s2`  out  3  seconds tens digit (0–5).
- `time_up`  out  1  registered. High in EXPIRED.
- `state`  out  2  current state encoding, for debug and display.

## Operation

- **States:** IDLE=0, RUNNING=1, PAUSED=2, EXPIRED=3.
- **Reset values:** `state`=IDLE, `s1`=START_S1, `s2`=START_S2, prescaler=0, `enable_m`=0, `time_up`=0. Reset has priority over every other event and can be applied in any state.
- **IDLE:**
  - `start`=1 and `pause`=0 → RUNNING, unless {m2,m1,s2,s1} are all zero, in which case → EXPIRED.
  - `pause` has priority over `start`.
- **RUNNING:**
  - The prescaler counts 0..TICK_DIV-1 and wraps.
  - A tick fires on the cycle the prescaler equals TICK_DIV-1.
  - `pause`=1 → PAUSED, evaluated before the tick. A tick coinciding with the pause request is discarded and the prescaler holds its value.
- **PAUSED:** prescaler and digits frozen. `pause`=0 → RUNNING, and counting resumes from the held prescaler value. `start` is ignored.
- **Tick handling (RUNNING only):**
  - s1>0: s1 ← s1−1.
  - s1=0, s2>0: s1 ← 9, s2 ← s2−1.
  - s1=0, s2=0, minutes ≠ 0: s1 ← 9, s2 ← 5, and `enable_m` ← 1 for exactly one cycle.
  - s1=0, s2=0, minutes = 0: cannot occur, because EXPIRED is entered first.
- **Expiry:** the tick whose decrement yields s2=0, s1=0 while m1=0 and m2=0 moves the block to EXPIRED on the same edge the digits update. `time_up`=1 from the next cycle.
- **EXPIRED:** sticky until `rst_n`. Digits hold 0:00, `enable_m` is never asserted, and `start`/`pause` are ignored.
- **Width rules:**
  - Prescaler width is $clog2(TICK_DIV).
  - Digits never leave BCD range.
  - No wrap from 0:00 to 9:59.

## Timing

- Digit update: registered, visible the cycle after the tick cycle.
- `enable_m`: high in the cycle after the borrow tick, for one cycle only. The minutes counter updates m1/m2 at the end of that cycle, so minutes lag seconds by one cycle.
- Expiry check: compares against the pre-update m1/m2. This is valid because no `enable_m` pulse is in flight whenever minutes are already 0.
- Back-to-back ticks (TICK_DIV=2): `enable_m` must still be a single-cycle pulse, separated from any earlier pulse by at least 59 ticks.
- `time_up`: asserts on the edge after the EXPIRED transition. There is no combinational path from inputs to any output.

## Structure

- **Package `game_timer_pkg`:**
  - state typedef: 2-bit enum IDLE/RUNNING/PAUSED/EXPIRED.
  - constants: SEC_ONES_MAX=9, SEC_TENS_MAX=5.
- **Sub-module `tick_prescaler`:**
  - parameter TICK_DIV.
  - inputs `clk`, `rst_n`, `run`.
  - output `tick`, asserted for one cycle at count TICK_DIV-1. The count holds while `run`=0.
- **Top:** FSM and seconds/borrow logic (about 150–250 lines total).

## Test plan

Use TICK_DIV=4 and minutes model initialised to m1=1, m2=0 in all scenarios.

1. **Reset then run:** `rst_n`=0 for 2 cycles, then `start`=1.
   - state IDLE→RUNNING one cycle after `start`.
   - First tick after 4 cycles: 0:00 seconds → s2=5, s1=9, with `enable_m` pulsed once and m1 going 1→0.
2. **Full countdown:** continue scenario 1 for 59 more ticks.
   - Seconds reach 00 with m=0.
   - state=EXPIRED and `time_up`=1 one cycle later.
   - No further `enable_m` pulses.
3. **Pause mid-count:** `pause`=1 at prescaler=2 for 20 cycles, then `pause`=0.
   - Digits unchanged throughout; state=PAUSED.
   - Next tick arrives 2 cycles after release.
4. **Start at 0:00:** minutes model at 0, START_S1=START_S2=0, `start`=1.
   - EXPIRED next cycle, `time_up`=1, zero `enable_m` pulses.
5. **Reset mid-operation:** assert `rst_n`=0 while RUNNING at 0:37.
   - Next cycle: state=IDLE, s2:s1=START values, prescaler=0, `enable_m`=0, `time_up`=0.
6. **Simultaneous `start` and `pause` in IDLE:** remains IDLE.
   - Dropping `pause` with `start` still high → RUNNING next cycle.
